// File: rtl/udp_pkg.sv
// Shared definitions for the UDP receive path.
//   rxbuf_state_t   : receive-buffer FSM states
//   UDP_WORD_BYTES  : bytes per payload word
//   words_for_bytes : number of 32-bit words needed to hold n bytes
//   sat_inc16       : 16-bit increment that holds at all-ones
package udp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DROP  = 2'd2,
        READY = 2'd3
    } rxbuf_state_t;

    localparam int UDP_WORD_BYTES = 4;

    // ceil(n / 4): the word index plus one more word for any trailing bytes.
    function automatic logic [15:0] words_for_bytes(input logic [15:0] n);
        return {2'b00, n[15:2]} + {15'd0, |n[1:0]};
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? 16'hFFFF : (v + 16'd1);
    endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port payload RAM: one write port, one registered read port.
// Ports:
//   clk, rst        : clock, synchronous active-high reset (read register only)
//   we/waddr/wdata  : write port
//   re/raddr        : read request; rdata updates one cycle later
//   rdata           : registered read data, holds while re=0
module sdp_ram #(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem_r [DEPTH_WORDS];
    logic [31:0] rdata_r;

    // Payload storage; contents are not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read port; value holds when no read is requested.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_r <= 32'd0;
        end else if (re) begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/udp_rx_pkt_buf.sv
// Single-packet receive buffer between the UDP rx stream and the MMIO side.
// Captures one datagram's payload words into a local RAM, latches its length
// and ports, presents it until the CPU releases it, and counts dropped packets.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   rxd_wr_en/rxd_wr_data          : payload word stream (first byte in [31:24])
//   rxd_pkt_done                   : end-of-datagram pulse
//   rxd_wr_byte_num, rx_src_port,
//   rx_dest_port                   : datagram attributes, valid with rxd_pkt_done
//   listen_port                    : accepted dest port, 0 accepts all
//   pkt_valid, pkt_byte_num,
//   pkt_src_port, pkt_dest_port    : held-packet status and latched fields
//   rd_en/rd_addr/rd_data          : CPU word read, data one cycle after rd_en
//   pkt_release                    : frees the buffer
//   drop_cnt                       : saturating dropped-packet counter
module udp_rx_pkt_buf
    import udp_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rxd_wr_en,
    input  logic [31:0]   rxd_wr_data,
    input  logic          rxd_pkt_done,
    input  logic [15:0]   rxd_wr_byte_num,
    input  logic [15:0]   rx_src_port,
    input  logic [15:0]   rx_dest_port,
    input  logic [15:0]   listen_port,
    output logic          pkt_valid,
    output logic [15:0]   pkt_byte_num,
    output logic [15:0]   pkt_src_port,
    output logic [15:0]   pkt_dest_port,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data,
    input  logic          pkt_release,
    output logic [15:0]   drop_cnt
);

    localparam logic [AW:0] PTR_FULL = (AW+1)'(DEPTH_WORDS);

    rxbuf_state_t state_r;
    logic [AW:0]  wr_ptr_r;
    logic         pkt_valid_r;
    logic [15:0]  pkt_byte_num_r;
    logic [15:0]  pkt_src_port_r;
    logic [15:0]  pkt_dest_port_r;
    logic [15:0]  drop_cnt_r;

    logic         wr_hit_s;
    logic         overflow_s;
    logic         ram_we_s;
    logic [16:0]  words_written_s;
    logic         port_ok_s;
    logic         len_ok_s;
    logic         accept_s;

    // Write qualification and end-of-datagram accept decision.
    always_comb begin
        wr_hit_s        = 1'b0;
        overflow_s      = 1'b0;
        ram_we_s        = 1'b0;
        words_written_s = 17'd0;
        port_ok_s       = 1'b0;
        len_ok_s        = 1'b0;
        accept_s        = 1'b0;
        if ((state_r == IDLE) || (state_r == FILL)) begin
            wr_hit_s = rxd_wr_en;
        end else begin
            wr_hit_s = 1'b0;
        end
        // A write with the pointer already at capacity never reaches the RAM.
        overflow_s = wr_hit_s && (wr_ptr_r == PTR_FULL);
        ram_we_s   = wr_hit_s && !overflow_s;
        // A write coinciding with rxd_pkt_done counts towards the length.
        words_written_s = 17'(wr_ptr_r) + 17'(ram_we_s);
        port_ok_s = (listen_port == 16'd0) || (rx_dest_port == listen_port);
        len_ok_s  = (words_written_s == {1'b0, words_for_bytes(rxd_wr_byte_num)});
        accept_s  = port_ok_s && len_ok_s && !overflow_s;
    end

    // Buffer FSM with write pointer, latched packet fields and drop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= IDLE;
            wr_ptr_r        <= '0;
            pkt_valid_r     <= 1'b0;
            pkt_byte_num_r  <= 16'd0;
            pkt_src_port_r  <= 16'd0;
            pkt_dest_port_r <= 16'd0;
            drop_cnt_r      <= 16'd0;
        end else begin
            case (state_r)
                IDLE, FILL: begin
                    if (rxd_pkt_done) begin
                        wr_ptr_r <= '0;
                        if (accept_s) begin
                            state_r         <= READY;
                            pkt_valid_r     <= 1'b1;
                            pkt_byte_num_r  <= rxd_wr_byte_num;
                            pkt_src_port_r  <= rx_src_port;
                            pkt_dest_port_r <= rx_dest_port;
                        end else begin
                            state_r    <= IDLE;
                            drop_cnt_r <= sat_inc16(drop_cnt_r);
                        end
                    end else if (overflow_s) begin
                        state_r  <= DROP;
                        wr_ptr_r <= '0;
                    end else if (ram_we_s) begin
                        state_r  <= FILL;
                        wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
                    end else begin
                        state_r <= state_r;
                    end
                end
                DROP: begin
                    if (rxd_pkt_done) begin
                        state_r    <= IDLE;
                        drop_cnt_r <= sat_inc16(drop_cnt_r);
                    end else begin
                        state_r <= DROP;
                    end
                end
                READY: begin
                    // Every datagram finishing while a packet is held is lost.
                    if (rxd_pkt_done) begin
                        drop_cnt_r <= sat_inc16(drop_cnt_r);
                    end else begin
                        drop_cnt_r <= drop_cnt_r;
                    end
                    if (pkt_release) begin
                        state_r     <= IDLE;
                        pkt_valid_r <= 1'b0;
                        wr_ptr_r    <= '0;
                    end else begin
                        state_r <= READY;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    wr_ptr_r    <= '0;
                    pkt_valid_r <= 1'b0;
                end
            endcase
        end
    end

    sdp_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we_s),
        .waddr (wr_ptr_r[AW-1:0]),
        .wdata (rxd_wr_data),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    assign pkt_valid     = pkt_valid_r;
    assign pkt_byte_num  = pkt_byte_num_r;
    assign pkt_src_port  = pkt_src_port_r;
    assign pkt_dest_port = pkt_dest_port_r;
    assign drop_cnt      = drop_cnt_r;

endmodule

// File: tb/tb_udp_rx_pkt_buf.sv
module tb_udp_rx_pkt_buf;

    localparam int DEPTH = 256;
    localparam int AW    = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rxd_wr_en = 1'b0;
    logic [31:0]   rxd_wr_data = 32'd0;
    logic          rxd_pkt_done = 1'b0;
    logic [15:0]   rxd_wr_byte_num = 16'd0;
    logic [15:0]   rx_src_port = 16'd0;
    logic [15:0]   rx_dest_port = 16'd0;
    logic [15:0]   listen_port = 16'd0;
    logic          pkt_valid;
    logic [15:0]   pkt_byte_num;
    logic [15:0]   pkt_src_port;
    logic [15:0]   pkt_dest_port;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [31:0]   rd_data;
    logic          pkt_release = 1'b0;
    logic [15:0]   drop_cnt;

    udp_rx_pkt_buf #(.DEPTH_WORDS(DEPTH), .AW(AW)) dut (
        .clk             (clk),
        .rst             (rst),
        .rxd_wr_en       (rxd_wr_en),
        .rxd_wr_data     (rxd_wr_data),
        .rxd_pkt_done    (rxd_pkt_done),
        .rxd_wr_byte_num (rxd_wr_byte_num),
        .rx_src_port     (rx_src_port),
        .rx_dest_port    (rx_dest_port),
        .listen_port     (listen_port),
        .pkt_valid       (pkt_valid),
        .pkt_byte_num    (pkt_byte_num),
        .pkt_src_port    (pkt_src_port),
        .pkt_dest_port   (pkt_dest_port),
        .rd_en           (rd_en),
        .rd_addr         (rd_addr),
        .rd_data         (rd_data),
        .pkt_release     (pkt_release),
        .drop_cnt        (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          nwords;
        logic [15:0] bytes;
        logic [15:0] dest;
        logic [15:0] listen;
        bit          coinc;
        bit          exp_valid;
        logic [31:0] base;
    } vec_t;

    vec_t        vecs [10];
    logic [31:0] wtab [3];
    int          vec_cnt = 0;
    int          err_cnt = 0;
    logic [15:0] drop_exp;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Sends nwords words; data from wtab when use_tab, else base+i.
    task automatic send_pkt(input int nwords, input bit use_tab, input logic [31:0] base,
                            input logic [15:0] bytes, input logic [15:0] src,
                            input logic [15:0] dest, input bit coinc);
        for (int i = 0; i < nwords; i++) begin
            rxd_wr_en   = 1'b1;
            rxd_wr_data = use_tab ? wtab[i] : (base + 32'(i));
            if (coinc && (i == nwords - 1)) begin
                rxd_pkt_done    = 1'b1;
                rxd_wr_byte_num = bytes;
                rx_src_port     = src;
                rx_dest_port    = dest;
            end
            tick();
        end
        rxd_wr_en = 1'b0;
        if (!coinc || nwords == 0) begin
            rxd_pkt_done    = 1'b1;
            rxd_wr_byte_num = bytes;
            rx_src_port     = src;
            rx_dest_port    = dest;
            tick();
        end
        rxd_pkt_done    = 1'b0;
        rxd_wr_byte_num = 16'd0;
        rx_src_port     = 16'd0;
        rx_dest_port    = 16'd0;
    endtask

    task automatic rd_word(input logic [AW-1:0] a);
        rd_en   = 1'b1;
        rd_addr = a;
        tick();
        rd_en   = 1'b0;
    endtask

    task automatic release_pkt();
        pkt_release = 1'b1;
        tick();
        pkt_release = 1'b0;
    endtask

    initial begin
        wtab[0] = 32'hDEADBEEF;
        wtab[1] = 32'h01020304;
        wtab[2] = 32'hAABB0000;

        //          nwords bytes    dest      listen    coinc valid base
        vecs[0] = '{257, 16'd1028, 16'd5000, 16'd5000, 1'b0, 1'b0, 32'h1000_0000};
        vecs[1] = '{1,   16'd4,    16'd5000, 16'd5000, 1'b0, 1'b1, 32'h2000_0000};
        vecs[2] = '{2,   16'd8,    16'd6000, 16'd5000, 1'b0, 1'b0, 32'h3000_0000};
        vecs[3] = '{2,   16'd8,    16'd6000, 16'd0,    1'b0, 1'b1, 32'h4000_0000};
        vecs[4] = '{2,   16'd5,    16'd5000, 16'd5000, 1'b1, 1'b1, 32'h5000_0000};
        vecs[5] = '{1,   16'd5,    16'd5000, 16'd5000, 1'b1, 1'b0, 32'h6000_0000};
        vecs[6] = '{0,   16'd0,    16'd7,    16'd0,    1'b0, 1'b1, 32'h7000_0000};
        vecs[7] = '{3,   16'd9,    16'd80,   16'd0,    1'b0, 1'b1, 32'h8000_0000};
        vecs[8] = '{3,   16'd8,    16'd80,   16'd0,    1'b0, 1'b0, 32'h9000_0000};
        vecs[9] = '{256, 16'd1024, 16'd5000, 16'd5000, 1'b1, 1'b1, 32'hA000_0000};

        // Reset state.
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_pkt_valid", {31'd0, pkt_valid}, 32'd0);
        chk("rst_byte_num", {16'd0, pkt_byte_num}, 32'd0);
        chk("rst_src_port", {16'd0, pkt_src_port}, 32'd0);
        chk("rst_dest_port", {16'd0, pkt_dest_port}, 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);

        // Basic 10-byte datagram and reads.
        listen_port = 16'd5000;
        send_pkt(3, 1'b1, 32'd0, 16'd10, 16'd1234, 16'd5000, 1'b0);
        chk("p1_valid", {31'd0, pkt_valid}, 32'd1);
        chk("p1_byte_num", {16'd0, pkt_byte_num}, 32'd10);
        chk("p1_src", {16'd0, pkt_src_port}, 32'd1234);
        chk("p1_dest", {16'd0, pkt_dest_port}, 32'd5000);
        for (int i = 0; i < 3; i++) begin
            rd_word(AW'(i));
            chk($sformatf("p1_rd%0d", i), rd_data, wtab[i]);
        end
        tick();
        chk("p1_rd_hold", rd_data, 32'hAABB0000);

        // Second datagram while READY is dropped and does not touch RAM.
        send_pkt(2, 1'b0, 32'h5555_0000, 16'd8, 16'd1, 16'd5000, 1'b0);
        chk("busy_valid", {31'd0, pkt_valid}, 32'd1);
        chk("busy_drop", {16'd0, drop_cnt}, 32'd1);
        chk("busy_byte_num", {16'd0, pkt_byte_num}, 32'd10);
        rd_word(AW'(0));
        chk("busy_rd0", rd_data, 32'hDEADBEEF);
        release_pkt();
        chk("rel_valid", {31'd0, pkt_valid}, 32'd0);
        release_pkt();
        chk("rel_idle_drop", {16'd0, drop_cnt}, 32'd1);
        drop_exp = 16'd1;

        // Table-driven packet vectors.
        for (int k = 0; k < 10; k++) begin
            listen_port = vecs[k].listen;
            send_pkt(vecs[k].nwords, 1'b0, vecs[k].base, vecs[k].bytes,
                     16'(7000 + k), vecs[k].dest, vecs[k].coinc);
            if (!vecs[k].exp_valid) drop_exp = drop_exp + 16'd1;
            chk($sformatf("v%0d_valid", k), {31'd0, pkt_valid}, {31'd0, vecs[k].exp_valid});
            chk($sformatf("v%0d_drop", k), {16'd0, drop_cnt}, {16'd0, drop_exp});
            if (vecs[k].exp_valid) begin
                chk($sformatf("v%0d_bytes", k), {16'd0, pkt_byte_num}, {16'd0, vecs[k].bytes});
                chk($sformatf("v%0d_src", k), {16'd0, pkt_src_port}, 32'(7000 + k));
                if (vecs[k].nwords > 0) begin
                    rd_word(AW'(vecs[k].nwords - 1));
                    chk($sformatf("v%0d_rdlast", k), rd_data,
                        vecs[k].base + 32'(vecs[k].nwords - 1));
                    rd_word(AW'(0));
                    chk($sformatf("v%0d_rd0", k), rd_data, vecs[k].base);
                end
                release_pkt();
                chk($sformatf("v%0d_rel", k), {31'd0, pkt_valid}, 32'd0);
            end
        end

        // Reset in the middle of FILL discards the partial packet uncounted.
        listen_port = 16'd0;
        rxd_wr_en   = 1'b1;
        rxd_wr_data = 32'h1111_1111;
        tick();
        rxd_wr_data = 32'h2222_2222;
        tick();
        rxd_wr_en = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_drop", {16'd0, drop_cnt}, 32'd0);
        send_pkt(1, 1'b0, 32'hC0DE_0000, 16'd4, 16'd42, 16'd99, 1'b0);
        chk("post_rst_valid", {31'd0, pkt_valid}, 32'd1);
        chk("post_rst_drop", {16'd0, drop_cnt}, 32'd0);
        rd_word(AW'(0));
        chk("post_rst_rd0", rd_data, 32'hC0DE_0000);

        // Saturation: hold done high while READY, one drop per cycle.
        rxd_pkt_done = 1'b1;
        for (int i = 0; i < 65534; i++) tick();
        rxd_pkt_done = 1'b0;
        chk("sat_fffe", {16'd0, drop_cnt}, 32'h0000FFFE);
        rxd_pkt_done = 1'b1;
        tick();
        rxd_pkt_done = 1'b0;
        chk("sat_ffff", {16'd0, drop_cnt}, 32'h0000FFFF);
        rxd_pkt_done = 1'b1;
        tick();
        tick();
        tick();
        rxd_pkt_done = 1'b0;
        chk("sat_hold", {16'd0, drop_cnt}, 32'h0000FFFF);
        chk("sat_valid", {31'd0, pkt_valid}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
